// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and minimum bit divider.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with wrap-bit pointers and a registered head; head/valid update one cycle after push or pop.
// Push is refused when full unless a pop lands in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_rd_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop    = i_pop && !w_empty;
  assign w_push   = i_push && (!w_full || w_pop);
  assign w_rd_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

  // The head register must see a byte written this cycle when it lands in the next read slot.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    if (w_push && (w_rd_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
      w_head_nxt = i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr <= w_rd_nxt;
      r_head   <= w_head_nxt;
    end
  end

  assign o_head  = r_head;
  assign o_valid = !w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: byte visible one cycle after the stop sample, buffered in a FIFO behind a valid/ready stream.
// A byte finishing while the FIFO is full and not being popped is dropped and flagged as overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] clk_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clear,
  output logic             irq,
  output logic             busy
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);
  localparam logic [BIT_W-1:0] IDX_ONE = BIT_W'(1);
  localparam logic [BIT_W-1:0] IDX_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [DIV_W-1:0]     r_div;
  logic [DIV_W-1:0]     r_cnt;
  logic [DIV_W-1:0]     w_div_eff;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_fall;
  logic                 w_cnt_zero;
  logic                 w_busy;
  logic                 w_push;
  logic                 w_frame_set;
  logic                 w_overrun_set;
  logic                 w_fifo_full;

  assign w_fall     = !r_rx_s && r_rx_prev;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_div_eff  = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
      ST_START: if (w_cnt_zero) w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_cnt_zero && (r_bit_idx == IDX_LAST)) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_cnt_zero) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state != ST_IDLE);
    w_push        = (r_state == ST_STOP) && w_cnt_zero && r_rx_s;
    w_frame_set   = (r_state == ST_STOP) && w_cnt_zero && !r_rx_s;
    w_overrun_set = w_push && w_fifo_full && !rx_ready;
  end

  // Counters load one less than the nominal count so the zero cycle is the sample cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_div <= w_div_eff;
            r_cnt <= (w_div_eff >> 1) - CNT_ONE;
          end
        end
        ST_START: begin
          if (w_cnt_zero) begin
            r_cnt     <= r_div - CNT_ONE;
            r_bit_idx <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (w_cnt_zero) begin
            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_cnt     <= r_div - CNT_ONE;
            r_bit_idx <= r_bit_idx + IDX_ONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // A new error event in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clear) begin
        r_frame_err <= 1'b0;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (err_clear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (rx_ready),
    .o_head  (rx_data),
    .o_valid (rx_valid),
    .o_full  (w_fifo_full)
  );

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign irq       = rx_valid;
  assign busy      = w_busy;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Chip-side 8N1 UART receiver for the user project: the far end of the testbench UART's transmit path (`ser_tx` → `mprj_io[5]`). It samples the asynchronous serial line, reassembles bytes, buffers them in a small FIFO and presents them on a valid/ready stream to the Wishbone register/firmware logic. It also raises a level interrupt while data is pending and records sticky framing and overrun errors until firmware clears them.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the bit-period divider.
- `clk  in  1`: system clock; all logic on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `rx  in  1`: raw serial input, idle high, asynchronous to `clk`.
- `clk_div  in  DIV_W`: clock cycles per bit. Values <4 are treated as 4. Latched at start-bit detection.
- `rx_data  out  8`: FIFO head byte. Reset 0x00.
- `rx_valid  out  1`: FIFO not empty. Reset 0.
- `rx_ready  in  1`: consumer pops the head when `rx_valid && rx_ready`.
- `frame_err  out  1`: sticky; stop bit sampled low. Reset 0.
- `overrun  out  1`: sticky; byte arrived with FIFO full. Reset 0.
- `err_clear  in  1`: single-cycle pulse clears both sticky flags.
- `irq  out  1`: equals `rx_valid`. Reset 0.
- `busy  out  1`: FSM not in IDLE. Reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1), then one extra register `rx_prev` for edge detection.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on synchronized falling edge (`rx_s==0 && rx_prev==1`), latch `div = max(clk_div,4)`, load counter with `div>>1`, go to START.
- START: count down; at zero, if `rx_s==0` load counter with `div`, bit index 0, go to DATA; if `rx_s==1` (glitch) return to IDLE, nothing recorded.
- DATA: count down; at zero sample `rx_s` into shift register LSB-first (bit 0 first), reload `div`; after bit 7 go to STOP.
- STOP: at counter zero sample `rx_s`. High → push byte; if FIFO full and no pop in that cycle, byte dropped and `overrun` set. Low → `frame_err` set, byte dropped. Both cases → IDLE.
- Break (line held low): after the framing error, IDLE re-arms only on a new falling edge, so a held-low line yields exactly one `frame_err` event.
- FIFO: push and pop in the same cycle are both honoured, including when full (no overrun) and when empty with push (byte visible next cycle).
- `err_clear` coincident with a new error event: set wins.
- Counter width `DIV_W`; `div>>1` truncates (odd dividers sample half a cycle early).

## Timing
- Let t = cycle in which the falling edge is detected (2 cycles after the `rx` edge due to synchronizer).
- Start confirmation at t+`div>>1`; data bit i sampled at t+`div>>1`+(i+1)·`div`; stop sampled at t+`div>>1`+9·`div`.
- FIFO write on the stop-sample edge; `rx_valid` high from the next cycle (latency 1 cycle after stop sample).
- Pop: `rx_data`/`rx_valid` update the cycle after the handshake.
- Back-to-back frames: a start edge detected in the cycle after STOP exits is accepted; no idle time required beyond the stop bit.
- Reset asserted mid-frame: FSM to IDLE, FIFO emptied, flags cleared, partial byte discarded immediately (asynchronous).

## Structure
- `uart_pkg`: FSM state enum, `DATA_BITS=8`, `MIN_DIV=4`; shared with the later transmitter.
- Sub-module `uart_rx_fifo` (parameterized depth, read/write pointers with an extra wrap bit for full/empty, registered head output). Synchronizer, FSM, counter and flags stay in `uart_rx_core`.

## Test plan
- `clk_div=16`, send 0x3D (61) 8N1, `rx_ready=1` → `rx_data=0x3D` with `rx_valid` for one cycle, at t+8+144+1; `frame_err=overrun=0`.
- `clk_div=4167` (40 MHz, 9600 baud), send 0x0F then 0xA5 back-to-back → two bytes in order, `irq` high while pending.
- 4-cycle low glitch on `rx` with `clk_div=16` → FSM returns to IDLE, no push, no flags.
- Send 0x55 with stop bit forced low → `frame_err=1`, FIFO empty; `err_clear` pulse → `frame_err=0`.
- `rx_ready=0`, send 0x01..0x05 with `FIFO_DEPTH=4` → FIFO holds 0x01–0x04, `overrun=1`; drain gives 0x01,0x02,0x03,0x04.
- Assert `rst_n=0` after data bit 3 of 0x3D, release, send 0x61 → only 0x61 received, all outputs at reset values during reset.
